// File: rtl/stream_serializer.sv
// +---------------------------------------------------------------------------+
// | stream_serializer : IN_W -> OUT_W width-down converter, valid/ready both   |
// | sides, one-word holding buffer, selectable beat order, last propagation.   |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module stream_serializer #(
   parameter int IN_W      = 32,
   parameter int OUT_W     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [IN_W-1:0]  data_i,
   input  logic             valid_i,
   input  logic             last_i,
   output logic             ready_o,
   output logic [OUT_W-1:0] data_o,
   output logic             valid_o,
   output logic             last_o,
   input  logic             ready_i,
   output logic             busy_o
);

   localparam int RATIO = IN_W / OUT_W;
   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

   generate
      if ((RATIO < 2) || ((IN_W % OUT_W) != 0)) begin : g_bad_ratio
         $error("stream_serializer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [IN_W-1:0]  sr, sr_nxt, hb, hb_nxt;
   logic             sr_last, sr_last_nxt, hb_last, hb_last_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic             in_hs, out_hs, final_beat;
   logic [IN_W-1:0]  sr_shifted;
   logic [OUT_W-1:0] head_beat;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= EMPTY;
         sr      <= '0;
         sr_last <= 1'b0;
         hb      <= '0;
         hb_last <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         sr      <= sr_nxt;
         sr_last <= sr_last_nxt;
         hb      <= hb_nxt;
         hb_last <= hb_last_nxt;
         cnt     <= cnt_nxt;
      end
   end

   assign ready_o    = (state != TWO);
   assign valid_o    = (state != EMPTY);
   assign busy_o     = valid_o;
   assign in_hs      = valid_i & ready_o;
   assign out_hs     = valid_o & ready_i;
   assign final_beat = out_hs & (cnt == CNT_MAX);
   // The next beat always sits at the output end, so shifting toward it exposes the following slice.
   assign sr_shifted = MSB_FIRST ? (sr << OUT_W) : (sr >> OUT_W);

   always_comb begin
      state_nxt   = state;
      sr_nxt      = sr;
      sr_last_nxt = sr_last;
      hb_nxt      = hb;
      hb_last_nxt = hb_last;
      cnt_nxt     = cnt;
      case (state)
         EMPTY: begin
            if (in_hs) begin
               sr_nxt      = data_i;
               sr_last_nxt = last_i;
               cnt_nxt     = '0;
               state_nxt   = ONE;
            end
         end
         ONE: begin
            if (final_beat) begin
               cnt_nxt = '0;
               if (in_hs) begin
                  sr_nxt      = data_i;
                  sr_last_nxt = last_i;
               end else begin
                  sr_nxt      = '0;
                  sr_last_nxt = 1'b0;
                  state_nxt   = EMPTY;
               end
            end else begin
               if (out_hs) begin
                  sr_nxt  = sr_shifted;
                  cnt_nxt = cnt + CNT_W'(1);
               end
               if (in_hs) begin
                  hb_nxt      = data_i;
                  hb_last_nxt = last_i;
                  state_nxt   = TWO;
               end
            end
         end
         TWO: begin
            if (final_beat) begin
               sr_nxt      = hb;
               sr_last_nxt = hb_last;
               hb_nxt      = '0;
               hb_last_nxt = 1'b0;
               cnt_nxt     = '0;
               state_nxt   = ONE;
            end else if (out_hs) begin
               sr_nxt  = sr_shifted;
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = EMPTY;
         end
      endcase
   end

   generate
      if (MSB_FIRST) begin : g_msb_head
         assign head_beat = sr[IN_W-1 -: OUT_W];
      end else begin : g_lsb_head
         assign head_beat = sr[OUT_W-1:0];
      end
   endgenerate

   assign data_o = valid_o ? head_beat : '0;
   assign last_o = sr_last & (cnt == CNT_MAX) & valid_o;

endmodule

`default_nettype wire

// File: tb/tb_stream_serializer.sv
// +---------------------------------------------------------------------------+
// | tb_stream_serializer : scoreboard bench, MSB-first and LSB-first instances |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_stream_serializer;

   localparam int IN_W  = 32;
   localparam int OUT_W = 8;
   localparam int RATIO = IN_W / OUT_W;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [IN_W-1:0]  data_i = '0;
   logic             valid_i = 1'b0;
   logic             last_i = 1'b0;
   logic             ready_i = 1'b1;

   logic             ready_o, valid_o, last_o, busy_o;
   logic [OUT_W-1:0] data_o;
   logic             ready_l, valid_l, last_l, busy_l;
   logic [OUT_W-1:0] data_l;

   stream_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .reset_n(reset_n), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
      .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
      .ready_i(ready_i), .busy_o(busy_o)
   );

   stream_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .reset_n(reset_n), .data_i(data_i), .valid_i(valid_i), .last_i(last_i),
      .ready_o(ready_l), .data_o(data_l), .valid_o(valid_l), .last_o(last_l),
      .ready_i(ready_i), .busy_o(busy_l)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic             l;
   } beat_t;

   beat_t q_m[$];
   beat_t q_l[$];
   beat_t exp_b;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int beats = 0;
   int first_cyc = -1;
   int last_cyc = -1;
   int ready_lo = 0;
   int last_cnt = 0;
   int last_beat = 0;
   int acc_cyc = 0;

   logic             stall_p = 1'b0;
   logic [OUT_W-1:0] data_p = '0;
   logic             last_p = 1'b0;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   // Scoreboard consumer: one pop per output handshake, on both orderings.
   always @(negedge clk) begin
      if (reset_n) begin
         if (stall_p) begin
            check_value("stall_data", data_o, data_p);
            check_value("stall_last", last_o, last_p);
         end
         if (!ready_o) ready_lo++;
         if (!valid_o) check_value("idle_data", data_o, 0);
         if (!valid_l) check_value("idle_data_lsb", data_l, 0);
         if (valid_o && ready_i) begin
            if (q_m.size() == 0) check_value("unexpected_beat", 1, 0);
            else begin
               exp_b = q_m.pop_front();
               check_value("beat_msb", data_o, exp_b.d);
               check_value("last_msb", last_o, exp_b.l);
            end
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
            if (last_o) begin
               last_cnt++;
               last_beat = beats;
            end
         end
         if (valid_l && ready_i) begin
            if (q_l.size() == 0) check_value("unexpected_beat_lsb", 1, 0);
            else begin
               exp_b = q_l.pop_front();
               check_value("beat_lsb", data_l, exp_b.d);
               check_value("last_lsb", last_l, exp_b.l);
            end
         end
      end
      stall_p = reset_n && valid_o && !ready_i;
      data_p  = data_o;
      last_p  = last_o;
   end

   task automatic push_word(input logic [IN_W-1:0] d, input logic l);
      beat_t b;
      for (int i = 0; i < RATIO; i++) begin
         b.l = l && (i == RATIO - 1);
         b.d = d[(RATIO-1-i)*OUT_W +: OUT_W];
         q_m.push_back(b);
         b.d = d[i*OUT_W +: OUT_W];
         q_l.push_back(b);
      end
   endtask

   // Called just after a rising edge; returns just after the edge that accepts the word.
   task automatic send_word(input logic [IN_W-1:0] d, input logic l);
      int n = 0;
      data_i  = d;
      last_i  = l;
      valid_i = 1'b1;
      @(negedge clk);
      while (!ready_o && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready_o) check_value("ready_timeout", 0, 1);
      else begin
         acc_cyc = cyc;
         push_word(d, l);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      valid_i = 1'b0;
      @(negedge clk);
      while (busy_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_value("idle_timeout", busy_o, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      beats = 0;
      first_cyc = -1;
      last_cyc = -1;
      ready_lo = 0;
      last_cnt = 0;
      last_beat = 0;
   endtask

   initial begin
      logic [3:0] pat;
      pat = 4'b1001;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_value("rst_valid", valid_o, 0);
      check_value("rst_data", data_o, 0);
      check_value("rst_last", last_o, 0);
      check_value("rst_busy", busy_o, 0);
      check_value("rst_ready", ready_o, 1);
      check_value("rst_valid_lsb", valid_l, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word, latency and contiguity
      clear_stats();
      send_word(32'hAABBCCDD, 1'b0);
      wait_idle();
      check_value("single_latency", first_cyc, acc_cyc + 1);
      check_value("single_beats", beats, 4);
      check_value("single_span", last_cyc - first_cyc + 1, 4);
      check_value("single_busy", busy_o, 0);
      check_value("single_valid", valid_o, 0);

      // Back-to-back stream with valid held high
      clear_stats();
      send_word(32'h01020304, 1'b0);
      send_word(32'h05060708, 1'b0);
      send_word(32'h090A0B0C, 1'b0);
      wait_idle();
      check_value("b2b_beats", beats, 12);
      check_value("b2b_span", last_cyc - first_cyc + 1, 12);
      check_value("b2b_ready_low", ready_lo > 0, 1);

      // Output backpressure
      clear_stats();
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               ready_i = pat[i % 4];
               @(posedge clk);
               #1;
            end
            ready_i = 1'b1;
         end
         begin
            send_word(32'hCAFEF00D, 1'b0);
            send_word(32'h13579BDF, 1'b0);
            valid_i = 1'b0;
         end
      join
      wait_idle();
      check_value("bp_beats", beats, 8);
      check_value("bp_ready_low", ready_lo > 0, 1);

      // Frame end on the second word only
      clear_stats();
      send_word(32'h21222324, 1'b0);
      send_word(32'h31323334, 1'b1);
      wait_idle();
      check_value("last_count", last_cnt, 1);
      check_value("last_position", last_beat, 8);

      // Asynchronous reset with the holding buffer loaded
      clear_stats();
      send_word(32'hDEADBEEF, 1'b0);
      send_word(32'h12345678, 1'b0);
      valid_i = 1'b0;
      @(posedge clk);
      #1;
      check_value("mid_beats", beats, 2);
      check_value("mid_ready", ready_o, 0);
      check_value("mid_busy", busy_o, 1);
      #1;
      reset_n = 1'b0;
      #1;
      check_value("arst_valid", valid_o, 0);
      check_value("arst_busy", busy_o, 0);
      check_value("arst_data", data_o, 0);
      check_value("arst_last", last_o, 0);
      check_value("arst_ready", ready_o, 1);
      check_value("arst_valid_lsb", valid_l, 0);
      q_m.delete();
      q_l.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      clear_stats();
      send_word(32'h11223344, 1'b0);
      wait_idle();
      check_value("post_rst_beats", beats, 4);
      check_value("post_rst_span", last_cyc - first_cyc + 1, 4);

      check_value("queue_empty", q_m.size() + q_l.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
